// File: rtl/rsa_crt_decrypt.sv
// RSA-CRT decryption engine: extended-Euclid qinv, time-shared square-and-multiply, Garner recombination.
// Optional build macro RSA_GCD_CHECK_EN adds a gcd(p,q)==1 check that aborts to DONE with err=1.
module rsa_crt_decrypt #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   p,
  input  logic [WIDTH-1:0]   q,
  input  logic [WIDTH-1:0]   d,
  input  logic [2*WIDTH-1:0] c,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] m,
  output logic [WIDTH-1:0]   qinv,
  output logic               err
);

  localparam int W2   = 2 * WIDTH;
  localparam int TW   = WIDTH + 2;
  localparam int PW   = W2 + 3;
  localparam int CNTW = $clog2(WIDTH) + 1;
  localparam logic [CNTW-1:0]  CNT_LAST = CNTW'(WIDTH - 1);
  localparam logic [CNTW-1:0]  CNT_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0]  CNT_ZERO = CNTW'(0);
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [TW-1:0]    ONE_T    = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0]    ZERO_T   = {TW{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE, S_INV, S_REDUCE, S_EXP_P, S_EXP_Q, S_RECOMB, S_DONE
  } state_t;

  // A zero modulus only occurs outside the contract; return 0 rather than X.
  function automatic logic [WIDTH-1:0] mod_w(input logic [W2-1:0] x, input logic [WIDTH-1:0] n);
    if (n == ZERO_W) return ZERO_W;
    else return WIDTH'(x % {ZERO_W, n});
  endfunction

  function automatic logic [W2-1:0] mul_w(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return {ZERO_W, a} * {ZERO_W, b};
  endfunction

  state_t                   state_r;
  logic [WIDTH-1:0]         p_r, q_r, d_r;
  logic [W2-1:0]            c_r;
  logic [WIDTH-1:0]         r0_r, r1_r, inv_r;
  logic signed [TW-1:0]     t0_r, t1_r;
  logic [WIDTH-1:0]         acc_r, base_r, exp_r, mod_r, dq_r, cq_r, m1_r;
  logic [CNTW-1:0]          cnt_r;
`ifdef RSA_GCD_CHECK_EN
  logic                     err_r;
`endif

  logic [WIDTH-1:0]         quot_s, rem_s, inv_norm_s;
  logic signed [PW-1:0]     prod_t_s;
  logic signed [TW-1:0]     t_next_s;
  logic [WIDTH-1:0]         pm1_s, qm1_s, dp_s, dq_s, cp_s, cq_s;
  logic [WIDTH-1:0]         acc_next_s, base_next_s, diff_s, h_s;
  logic [W2-1:0]            m_s;

  // Euclid quotient step with signed Bezout coefficient for q, plus normalisation into [0, p-1].
  always_comb begin
    quot_s = ZERO_W;
    rem_s  = ZERO_W;
    if (r1_r != ZERO_W) begin
      quot_s = r0_r / r1_r;
      rem_s  = r0_r % r1_r;
    end else begin
      quot_s = ZERO_W;
      rem_s  = ZERO_W;
    end
    prod_t_s = $signed({{(PW-WIDTH){1'b0}}, quot_s}) * $signed({{(PW-TW){t1_r[TW-1]}}, t1_r});
    t_next_s = TW'($signed({{(PW-TW){t0_r[TW-1]}}, t0_r}) - prod_t_s);
    if (t0_r[TW-1]) inv_norm_s = t0_r[WIDTH-1:0] + p_r;
    else            inv_norm_s = t0_r[WIDTH-1:0];
  end

  // Reduction, shared exponentiation step and recombination arithmetic.
  always_comb begin
    pm1_s       = p_r - ONE_W;
    qm1_s       = q_r - ONE_W;
    dp_s        = mod_w({ZERO_W, d_r}, pm1_s);
    dq_s        = mod_w({ZERO_W, d_r}, qm1_s);
    cp_s        = mod_w(c_r, p_r);
    cq_s        = mod_w(c_r, q_r);
    acc_next_s  = mod_w(mul_w(acc_r, base_r), mod_r);
    base_next_s = mod_w(mul_w(base_r, base_r), mod_r);
    // acc_r holds m2 during RECOMB; the borrow path keeps diff non-negative.
    if (m1_r >= acc_r) diff_s = m1_r - acc_r;
    else               diff_s = m1_r + p_r - acc_r;
    h_s = mod_w(mul_w(inv_r, diff_s), p_r);
    m_s = {ZERO_W, acc_r} + mul_w(h_s, q_r);
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      m       <= {W2{1'b0}};
      qinv    <= ZERO_W;
      p_r     <= ZERO_W;
      q_r     <= ZERO_W;
      d_r     <= ZERO_W;
      c_r     <= {W2{1'b0}};
      r0_r    <= ZERO_W;
      r1_r    <= ZERO_W;
      inv_r   <= ZERO_W;
      t0_r    <= ZERO_T;
      t1_r    <= ZERO_T;
      acc_r   <= ZERO_W;
      base_r  <= ZERO_W;
      exp_r   <= ZERO_W;
      mod_r   <= ZERO_W;
      dq_r    <= ZERO_W;
      cq_r    <= ZERO_W;
      m1_r    <= ZERO_W;
      cnt_r   <= CNT_ZERO;
`ifdef RSA_GCD_CHECK_EN
      err_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            p_r     <= p;
            q_r     <= q;
            d_r     <= d;
            c_r     <= c;
            r0_r    <= p;
            r1_r    <= q;
            t0_r    <= ZERO_T;
            t1_r    <= ONE_T;
            busy    <= 1'b1;
`ifdef RSA_GCD_CHECK_EN
            err_r   <= 1'b0;
`endif
            state_r <= S_INV;
          end
        end
        S_INV: begin
          if (r1_r == ZERO_W) begin
            inv_r <= inv_norm_s;
`ifdef RSA_GCD_CHECK_EN
            if (r0_r != ONE_W) begin
              err_r   <= 1'b1;
              m       <= {W2{1'b0}};
              qinv    <= ZERO_W;
              busy    <= 1'b0;
              done    <= 1'b1;
              state_r <= S_DONE;
            end else begin
              state_r <= S_REDUCE;
            end
`else
            state_r <= S_REDUCE;
`endif
          end else begin
            r0_r <= r1_r;
            r1_r <= rem_s;
            t0_r <= t1_r;
            t1_r <= t_next_s;
          end
        end
        S_REDUCE: begin
          acc_r   <= ONE_W;
          base_r  <= cp_s;
          exp_r   <= dp_s;
          mod_r   <= p_r;
          dq_r    <= dq_s;
          cq_r    <= cq_s;
          cnt_r   <= CNT_ZERO;
          state_r <= S_EXP_P;
        end
        S_EXP_P, S_EXP_Q: begin
          if (exp_r[0]) acc_r <= acc_next_s;
          base_r <= base_next_s;
          exp_r  <= {1'b0, exp_r[WIDTH-1:1]};
          cnt_r  <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            cnt_r <= CNT_ZERO;
            if (state_r == S_EXP_P) begin
              // Hand the datapath over to the q half.
              if (exp_r[0]) m1_r <= acc_next_s;
              else          m1_r <= acc_r;
              acc_r   <= ONE_W;
              base_r  <= cq_r;
              exp_r   <= dq_r;
              mod_r   <= q_r;
              state_r <= S_EXP_Q;
            end else begin
              state_r <= S_RECOMB;
            end
          end
        end
        S_RECOMB: begin
          m       <= m_s;
          qinv    <= inv_r;
          busy    <= 1'b0;
          done    <= 1'b1;
          state_r <= S_DONE;
        end
        S_DONE: begin
          done    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

`ifdef RSA_GCD_CHECK_EN
  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rsa_crt_decrypt.sv
// Directed self-checking bench for rsa_crt_decrypt with hand-computed RSA-CRT vectors.
module tb_rsa_crt_decrypt;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] p, q, d;
  logic [63:0] c;
  logic        busy, done, err;
  logic [63:0] m;
  logic [31:0] qinv;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int dc0;

  rsa_crt_decrypt #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .p(p), .q(q), .d(d), .c(c),
    .busy(busy), .done(done), .m(m), .qinv(qinv), .err(err)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, {63'd0, done}, 64'd1);
  endtask

  // Called at a negedge with the DUT in IDLE; returns at the negedge where done is seen.
  task automatic run_op(input string tag, input logic [31:0] pp, input logic [31:0] qq,
                        input logic [31:0] dd, input logic [63:0] cc);
    p = pp; q = qq; d = dd; c = cc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(tag);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; p = 32'd0; q = 32'd0; d = 32'd0; c = 64'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_m",    m,             64'd0);
    check("rst_qinv", {32'd0, qinv}, 64'd0);
    check("rst_err",  {63'd0, err},  64'd0);
    rst = 1'b0;
    @(negedge clk);

    // m1=4 < m2=12 borrow path
    run_op("t1", 32'd61, 32'd53, 32'd2753, 64'd2790);
    check("t1_m",    m,             64'd65);
    check("t1_qinv", {32'd0, qinv}, 64'd38);
    check("t1_err",  {63'd0, err},  64'd0);
    check("t1_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check("t1_pulse", {63'd0, done}, 64'd0);

    run_op("t2a", 32'd61, 32'd53, 32'd2753, 64'd0);
    check("t2_c0", m, 64'd0);
    @(negedge clk);
    run_op("t2b", 32'd61, 32'd53, 32'd2753, 64'd1);
    check("t2_c1", m, 64'd1);
    @(negedge clk);

    run_op("t3", 32'd61, 32'd53, 32'd0, 64'd2790);
    check("t3_d0", m, 64'd1);
    @(negedge clk);

    // n=77, e=7, d=43: 2^7 mod 77 = 51; m1 == m2 == 2
    run_op("tx", 32'd11, 32'd7, 32'd43, 64'd51);
    check("tx_m",    m,             64'd2);
    check("tx_qinv", {32'd0, qinv}, 64'd8);
    @(negedge clk);

    // start held high through the run and the DONE cycle, inputs scrambled mid-run
    dc0 = done_cnt;
    p = 32'd61; q = 32'd53; d = 32'd2753; c = 64'd2790;
    start = 1'b1;
    @(negedge clk);
    check("t4_busy", {63'd0, busy}, 64'd1);
    p = 32'd11; q = 32'd7; d = 32'd5; c = {$urandom, $urandom};
    wait_done("t4");
    check("t4_m", m, 64'd65);
    @(negedge clk);
    start = 1'b0;
    check("t4_norestart", {63'd0, busy}, 64'd0);
    repeat (20) @(negedge clk);
    check("t4_onedone", 64'(done_cnt - dc0), 64'd1);
    check("t4_mhold", m, 64'd65);

    // reset in the middle of EXP_P
    p = 32'd61; q = 32'd53; d = 32'd2753; c = 64'd2790;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    check("t5_busy_pre", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    check("t5_busy", {63'd0, busy}, 64'd0);
    check("t5_m",    m,             64'd0);
    check("t5_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op("t5r", 32'd61, 32'd53, 32'd2753, 64'd2790);
    check("t5r_m", m, 64'd65);
    @(negedge clk);

    run_op("t6", 32'd61, 32'd61, 32'd2753, 64'd2790);
`ifdef RSA_GCD_CHECK_EN
    check("t6_err",  {63'd0, err},  64'd1);
    check("t6_m",    m,             64'd0);
    check("t6_qinv", {32'd0, qinv}, 64'd0);
    @(negedge clk);
    run_op("t6r", 32'd61, 32'd53, 32'd2753, 64'd2790);
    check("t6r_err", {63'd0, err}, 64'd0);
    check("t6r_m",   m,            64'd65);
`else
    check("t6_err", {63'd0, err}, 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
